// File: rtl/keypad_loader.sv
// Keypad entry front-end: debounces a one-hot 10-key pad and loads one BCD digit per press into the timer.
// Optional KEYPAD_RANGE_CHECK_EN adds a registered tens-of-seconds range flag on err_range.
module keypad_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic        clk,
  input  logic        clearn,
  input  logic [9:0]  keypad,
  input  logic        busy,
  input  logic        clear_entry,
  output logic [3:0]  data,
  output logic        load,
  output logic [11:0] shadow,
  output logic [1:0]  ndigits,
  output logic        err_range
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, LOAD, HOLD} state_t;

  state_t      state, state_nxt;
  logic [9:0]  key_q, key_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [11:0] shadow_nxt;
  logic [1:0]  nd_nxt;
  logic        key_valid;

  function automatic logic [3:0] enc(input logic [9:0] k);
    enc = 4'd0;
    for (int i = 0; i < 10; i++)
      if (k[i]) enc = 4'(i);
  endfunction

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign key_valid = (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0);
  assign load      = (state == LOAD);

  always_comb begin
    state_nxt = state;
    key_nxt   = key_q;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (key_valid && !busy) begin
          key_nxt   = keypad;
          cnt_nxt   = '0;
          state_nxt = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (keypad == key_q && !busy) begin
          if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) state_nxt = LOAD;
          else                                    cnt_nxt   = cnt + CNT_W'(1);
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD: state_nxt = HOLD;
      HOLD: begin
        if (keypad == 10'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A clear coinciding with LOAD still lets the new digit land in an empty shadow.
  always_comb begin
    shadow_nxt = shadow;
    nd_nxt     = ndigits;
    if (clear_entry) begin
      shadow_nxt = 12'd0;
      nd_nxt     = 2'd0;
    end
    if (state == LOAD) begin
      shadow_nxt = {shadow_nxt[7:0], data};
      nd_nxt     = (nd_nxt == 2'd3) ? 2'd3 : nd_nxt + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state   <= IDLE;
      key_q   <= '0;
      cnt     <= '0;
      data    <= '0;
      shadow  <= '0;
      ndigits <= '0;
    end else begin
      state   <= state_nxt;
      key_q   <= key_nxt;
      cnt     <= cnt_nxt;
      shadow  <= shadow_nxt;
      ndigits <= nd_nxt;
      if (state == DEBOUNCE && state_nxt == LOAD) data <= enc(key_q);
    end
  end

`ifdef KEYPAD_RANGE_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) err_q <= 1'b0;
    else         err_q <= (shadow_nxt[7:4] > 4'd5);
  end
  assign err_range = err_q;
`else
  assign err_range = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_loader.sv
// Bench for keypad_loader: vector table of presses, a load scoreboard, and hand sequences for bounce, busy, clear and reset corners.
module tb_keypad_loader;

  logic        clk = 1'b0;
  logic        clearn;
  logic [9:0]  keypad;
  logic        busy;
  logic        clear_entry;
  logic [3:0]  data;
  logic        load;
  logic [11:0] shadow;
  logic [1:0]  ndigits;
  logic        err_range;

  keypad_loader #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .clearn(clearn), .keypad(keypad), .busy(busy),
    .clear_entry(clear_entry), .data(data), .load(load),
    .shadow(shadow), .ndigits(ndigits), .err_range(err_range)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int nloads = 0;
  logic [3:0] exp_q[$];

`ifdef KEYPAD_RANGE_CHECK_EN
  localparam logic RANGE_ON = 1'b1;
`else
  localparam logic RANGE_ON = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every observed load pops the digit pushed when the press was driven.
  always @(negedge clk) begin
    if (clearn && load) begin
      nloads++;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_load: got data 0x%0h expected no load at %0t", data, $time);
      end else begin
        chk("load_data", {28'd0, data}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives key for n cycles and reports the first cycle (1-based) with load high, 0 if none.
  task automatic hold_watch(input logic [9:0] key, input int n, output int first);
    first = 0;
    keypad = key;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (load && first == 0) first = i;
    end
  endtask

  task automatic wait_load(input string name);
    int k;
    k = 0;
    while (!load && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!load) chk(name, 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [9:0]  key;
    logic        bsy;
    logic        exp_load;
    logic [3:0]  exp_code;
    logic [11:0] exp_shadow;
    logic [1:0]  exp_nd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int first, base;

    vecs[0] = '{10'b0000000010, 1'b0, 1'b1, 4'd1, 12'h051, 2'd2};
    vecs[1] = '{10'b0000001000, 1'b0, 1'b1, 4'd3, 12'h513, 2'd3};
    vecs[2] = '{10'b0000000001, 1'b0, 1'b1, 4'd0, 12'h130, 2'd3};
    vecs[3] = '{10'b0010000000, 1'b0, 1'b1, 4'd7, 12'h307, 2'd3};
    vecs[4] = '{10'b0000000011, 1'b0, 1'b0, 4'd0, 12'h307, 2'd3};
    vecs[5] = '{10'b0000000100, 1'b1, 1'b0, 4'd0, 12'h307, 2'd3};
    vecs[6] = '{10'b0000000000, 1'b0, 1'b0, 4'd0, 12'h307, 2'd3};
    vecs[7] = '{10'b1000000000, 1'b0, 1'b1, 4'd9, 12'h079, 2'd3};

    clearn = 1'b0; keypad = '0; busy = 1'b0; clear_entry = 1'b0;
    step(2);
    chk("reset_data", {28'd0, data}, 32'd0);
    chk("reset_load", {31'd0, load}, 32'd0);
    chk("reset_shadow", {20'd0, shadow}, 32'd0);
    chk("reset_ndigits", {30'd0, ndigits}, 32'd0);
    chk("reset_err", {31'd0, err_range}, 32'd0);
    clearn = 1'b1;
    step(2);

    // Key 5 held 10 cycles: one load, five cycles after it appears.
    exp_q.push_back(4'd5);
    base = nloads;
    hold_watch(10'b0000100000, 10, first);
    keypad = '0; step(3);
    chk("k5_latency", first, 5);
    chk("k5_count", nloads - base, 1);
    chk("k5_shadow", {20'd0, shadow}, 32'h005);
    chk("k5_ndigits", {30'd0, ndigits}, 32'd1);

    foreach (vecs[i]) begin
      base = nloads;
      if (vecs[i].exp_load) exp_q.push_back(vecs[i].exp_code);
      busy = vecs[i].bsy;
      keypad = vecs[i].key;
      step(8);
      keypad = '0; busy = 1'b0;
      step(3);
      chk($sformatf("vec%0d_loads", i), nloads - base, {31'd0, vecs[i].exp_load});
      chk($sformatf("vec%0d_shadow", i), {20'd0, shadow}, {20'd0, vecs[i].exp_shadow});
      chk($sformatf("vec%0d_ndigits", i), {30'd0, ndigits}, {30'd0, vecs[i].exp_nd});
    end

    // Key 8 bounces, then is stable: load only after four stable cycles.
    base = nloads;
    exp_q.push_back(4'd8);
    keypad = 10'b0100000000; step(1);
    keypad = '0;             step(1);
    keypad = 10'b0100000000; step(2);
    keypad = '0;             step(1);
    chk("bounce_noload", nloads - base, 0);
    hold_watch(10'b0100000000, 8, first);
    keypad = '0; step(3);
    chk("bounce_latency", first, 5);
    chk("bounce_count", nloads - base, 1);
    chk("bounce_shadow", {20'd0, shadow}, 32'h798);

    // busy raised mid-debounce aborts the press.
    base = nloads;
    keypad = 10'b0000010000; step(2);
    busy = 1'b1; step(3);
    keypad = '0; step(1);
    busy = 1'b0; step(6);
    chk("busy_mid_noload", nloads - base, 0);
    chk("busy_mid_shadow", {20'd0, shadow}, 32'h798);

    clear_entry = 1'b1; step(1); clear_entry = 1'b0;
    chk("clear_shadow", {20'd0, shadow}, 32'd0);
    chk("clear_ndigits", {30'd0, ndigits}, 32'd0);

    // Range flag: entering 0,7,2 puts 7 in the tens-of-seconds slot.
    exp_q.push_back(4'd0); keypad = 10'b0000000001; step(7); keypad = '0; step(2);
    exp_q.push_back(4'd7); keypad = 10'b0010000000; step(7); keypad = '0; step(2);
    exp_q.push_back(4'd2); keypad = 10'b0000000100; step(7); keypad = '0; step(2);
    chk("range_shadow", {20'd0, shadow}, 32'h072);
    chk("range_err", {31'd0, err_range}, {31'd0, RANGE_ON});
    clear_entry = 1'b1; step(1); clear_entry = 1'b0;
    chk("range_clr_shadow", {20'd0, shadow}, 32'd0);
    chk("range_clr_err", {31'd0, err_range}, 32'd0);

    // clear_entry in the LOAD cycle: the new digit lands in an empty shadow.
    exp_q.push_back(4'd4); keypad = 10'b0000010000; step(7); keypad = '0; step(2);
    chk("pre_clr_shadow", {20'd0, shadow}, 32'h004);
    exp_q.push_back(4'd6);
    keypad = 10'b0001000000;
    wait_load("clr_load_timeout");
    clear_entry = 1'b1; step(1); clear_entry = 1'b0;
    keypad = '0; step(2);
    chk("clr_load_shadow", {20'd0, shadow}, 32'h006);
    chk("clr_load_ndigits", {30'd0, ndigits}, 32'd1);

    // Reset during DEBOUNCE: outputs clear at once, no load afterwards.
    base = nloads;
    keypad = 10'b0000001000; step(2);
    #1 clearn = 1'b0; keypad = '0;
    #1 chk("rst_db_shadow", {20'd0, shadow}, 32'd0);
    chk("rst_db_ndigits", {30'd0, ndigits}, 32'd0);
    chk("rst_db_data", {28'd0, data}, 32'd0);
    step(1); clearn = 1'b1; step(10);
    chk("rst_db_noload", nloads - base, 0);

    // Reset during LOAD: load drops immediately and the press is lost.
    exp_q.push_back(4'd3);
    keypad = 10'b0000001000;
    wait_load("rst_load_timeout");
    #1 clearn = 1'b0; keypad = '0;
    #1 chk("rst_ld_load", {31'd0, load}, 32'd0);
    chk("rst_ld_data", {28'd0, data}, 32'd0);
    chk("rst_ld_shadow", {20'd0, shadow}, 32'd0);
    base = nloads;
    step(1); clearn = 1'b1; step(10);
    chk("rst_ld_noload", nloads - base, 0);
    chk("rst_ld_err", {31'd0, err_range}, 32'd0);

    chk("pending_loads", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/keypad_loader.md
Name: keypad_loader

Overview:
- Front-end entry block that writes into the countdown timer: converts a 10-key one-hot keypad into BCD digits, one per key press.
- Each accepted press emits one single-cycle load pulse with the BCD code on data.
- The timer shifts each loaded digit through its seconds-units, seconds-tens and minutes digits.
- Keeps a 12-bit shadow of the three digits as they are shifted in, so control logic and the bench can see the value that was entered.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a key is accepted (>=1).
- CNT_W, 3, width of the debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock, rising edge.
- clearn  input  1  asynchronous active-low reset.
- keypad  input  10  one-hot raw keys; bit k = digit k; already synchronised upstream.
- busy  input  1  timer running; entry inhibited while high.
- clear_entry  input  1  synchronous clear of the shadow and digit count.
- data  output  4  BCD digit to the timer; registered.
- load  output  1  one-cycle load strobe to the timer.
- shadow  output  12  {min, st, so} as shifted into the timer.
- ndigits  output  2  digits entered since the last clear; saturates at 3.
- err_range  output  1  entered tens-of-seconds digit > 5 (optional feature).

Behaviour:
- Reset (clearn=0, asynchronous):
  - state=IDLE; data=0, load=0, shadow=0, ndigits=0, err_range=0; debounce counter=0.
  - A reset in any state aborts the press; no load pulse is emitted.
- Valid key: keypad has exactly one bit set. Zero bits or two or more bits set is not a valid key.
- IDLE:
  - Valid key and busy=0: capture the one-hot pattern, set counter=0, go to DEBOUNCE.
  - Otherwise stay in IDLE.
- DEBOUNCE:
  - keypad equals the captured pattern and busy=0:
    - counter==DEBOUNCE_CYCLES-1 -> go to LOAD.
    - otherwise counter+1.
  - Pattern changes, or busy=1 -> go to IDLE. No load.
- LOAD: one cycle.
  - load=1; data=BCD of the captured key (0..9).
  - shadow <= {shadow[7:0], code}.
  - ndigits <= min(ndigits+1, 3).
  - Go to HOLD.
- HOLD:
  - Wait for one cycle with keypad==0, then go to IDLE.
  - A held key never repeats.
  - busy is ignored in this state.
- Latency: the first cycle a valid key is seen is cycle 0. load is asserted at cycle DEBOUNCE_CYCLES+1, in the LOAD state.
- data holds its last value after load drops. load is high for exactly one cycle per accepted press.
- clear_entry:
  - Sets shadow=0 and ndigits=0 on the next edge; FSM unaffected.
  - If it coincides with LOAD, the load still fires and the result is shadow={8'h00, code}, ndigits=1.
- Shadow overflow: the fourth and later digits shift the oldest digit out of shadow[11:8]. This matches the timer's own shift-in behaviour.
- Keypad bits are taken as already synchronised; this block adds no synchroniser.

Optional Feature:
- KEYPAD_RANGE_CHECK_EN defined:
  - err_range is a registered output, high while shadow[7:4] > 5.
  - It updates on the same edge as shadow; clear_entry clears it.
  - The load is still issued; the flag is advisory.
- Macro undefined: err_range is tied to 0 and the compare logic is absent.

Test Plan:
- Reset, then press keypad=10'b0000100000 (key 5) held for 10 cycles -> exactly one load, 5 cycles after the key appears (DEBOUNCE_CYCLES=4); data=4'h5, shadow=12'h005, ndigits=1.
- Press keys 1, 3, 0 with releases in between -> three load pulses; shadow=12'h130, ndigits=3. A fourth key, 7 -> shadow=12'h307, ndigits=3.
- Key 8 bounces 1,0,1,1,0 then is stable -> no load until 4 stable cycles; exactly one load, data=4'h8.
- keypad=10'b0000000011 (two keys), or busy=1 during a key 2 press -> no load; state returns to IDLE. Raise busy mid-DEBOUNCE -> no load.
- With KEYPAD_RANGE_CHECK_EN, enter 0, 7, 2 -> shadow=12'h072 (st=7 > 5), err_range=1. clear_entry -> shadow=0, err_range=0. Without the macro, err_range stays 0.
- Assert clearn low during DEBOUNCE and during LOAD -> all outputs go to 0 immediately; no load pulse after release.
